adder_arbiter_rr: RTL and testbench

ADDER_ARBITER_RR -- requirements
Module: adder_arbiter_rr

---
 rtl/adder_arbiter_rr_pkg.sv | 12 +
 rtl/adder_arbiter_rr_if.sv | 31 +++
 rtl/adder_arbiter_rr_adder_4bit.sv | 26 ++
 rtl/adder_arbiter_rr.sv | 82 ++++++++
 tb/tb_adder_arbiter_rr.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arbiter_rr_pkg.sv
// Shared types and constants for the
// two-requester shared-adder arbiter.
package adder_arbiter_rr_pkg;

  localparam int OPW = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } st_t;

endpackage

// File: rtl/adder_arbiter_rr_if.sv
// Request/operand/response bundle between
// the requesters+consumer and the arbiter.
import adder_arbiter_rr_pkg::*;

interface adder_arbiter_rr_if;

  logic [1:0]     req;
  logic [OPW-1:0] a0;
  logic [OPW-1:0] b0;
  logic [OPW-1:0] a1;
  logic [OPW-1:0] b1;
  logic [1:0]     gnt;
  logic           rsp_vld;
  logic           rsp_id;
  logic [OPW-1:0] rsp_sum;
  logic           rsp_cout;
  logic           rsp_rdy;

  modport master (
    output req, a0, b0, a1, b1, rsp_rdy,
    input  gnt, rsp_vld, rsp_id,
    input  rsp_sum, rsp_cout
  );

  modport slave (
    input  req, a0, b0, a1, b1, rsp_rdy,
    output gnt, rsp_vld, rsp_id,
    output rsp_sum, rsp_cout
  );

endinterface

// File: rtl/adder_arbiter_rr_adder_4bit.sv
// Ripple-carry adder, no carry-in.
// Shared by both requesters of the arbiter.
import adder_arbiter_rr_pkg::*;

module adder_4bit (
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [OPW-1:0] sum,
  output logic           cout
);

  logic [OPW:0] c;

  always_comb begin
    c   = '0;
    sum = '0;
    for (int i = 0; i < OPW; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i])
               | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[OPW];

endmodule

// File: rtl/adder_arbiter_rr.sv
// Two requesters share one adder; the
// result sits in a one-entry buffer.
import adder_arbiter_rr_pkg::*;

module adder_arbiter_rr #(
  parameter int FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_arbiter_rr_if.slave bus
);

  st_t            state;
  logic           last_gnt;
  logic           id_q;
  logic [OPW-1:0] sum_q;
  logic           cout_q;

  logic           permit;
  logic           pick1;
  logic [1:0]     gnt;
  logic [OPW-1:0] op_a;
  logic [OPW-1:0] op_b;
  logic [OPW-1:0] add_sum;
  logic           add_cout;

  assign permit = (state == ST_EMPTY)
               || bus.rsp_rdy;

  // On contention, fixed mode always picks 0.
  assign pick1 = (FIXED_PRIO == 0)
               ? ~last_gnt : 1'b0;

  always_comb begin
    gnt = 2'b00;
    if (rst_n && permit) begin
      unique case (1'b1)
        bus.req == 2'b01: gnt = 2'b01;
        bus.req == 2'b10: gnt = 2'b10;
        bus.req == 2'b11:
          gnt = pick1 ? 2'b10 : 2'b01;
        bus.req == 2'b00: gnt = 2'b00;
      endcase
    end
  end

  assign op_a = gnt[1] ? bus.a1 : bus.a0;
  assign op_b = gnt[1] ? bus.b1 : bus.b0;

  adder_4bit u_add (
    .a    (op_a),
    .b    (op_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      last_gnt <= 1'b1;
      id_q     <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else if (|gnt) begin
      state    <= ST_FULL;
      last_gnt <= gnt[1];
      id_q     <= gnt[1];
      sum_q    <= add_sum;
      cout_q   <= add_cout;
    end else if (state == ST_FULL
              && bus.rsp_rdy) begin
      state    <= ST_EMPTY;
    end
  end

  assign bus.gnt      = gnt;
  assign bus.rsp_vld  = (state == ST_FULL);
  assign bus.rsp_id   = id_q;
  assign bus.rsp_sum  = sum_q;
  assign bus.rsp_cout = cout_q;

endmodule

// File: tb/tb_adder_arbiter_rr.sv
// Bench: round-robin and fixed-priority
// instances share stimulus; model per instance.
module tb_adder_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = '0;
  logic [3:0] a0 = '0, b0 = '0;
  logic [3:0] a1 = '0, b1 = '0;
  logic       rdy = 1'b0;

  int nvec = 0;
  int nerr = 0;

  logic       m_vld  [2];
  logic       m_id   [2];
  logic [3:0] m_sum  [2];
  logic       m_cout [2];
  logic       m_last [2];

  adder_arbiter_rr_if if0 ();
  adder_arbiter_rr_if if1 ();

  assign if0.req = req;
  assign if0.a0 = a0;
  assign if0.b0 = b0;
  assign if0.a1 = a1;
  assign if0.b1 = b1;
  assign if0.rsp_rdy = rdy;
  assign if1.req = req;
  assign if1.a0 = a0;
  assign if1.b0 = b0;
  assign if1.a1 = a1;
  assign if1.b1 = b1;
  assign if1.rsp_rdy = rdy;

  adder_arbiter_rr #(.FIXED_PRIO(0)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  adder_arbiter_rr #(.FIXED_PRIO(1)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  always #5 clk = ~clk;

  function automatic void mreset(int k);
    m_vld[k]  = 1'b0;
    m_id[k]   = 1'b0;
    m_sum[k]  = '0;
    m_cout[k] = 1'b0;
    m_last[k] = 1'b1;
  endfunction

  function automatic logic [1:0] exp_gnt(int k);
    if (!rst_n) return 2'b00;
    if (m_vld[k] && !rdy) return 2'b00;
    case (req)
      2'b01: return 2'b01;
      2'b10: return 2'b10;
      2'b11:
        if (k == 1 || m_last[k]) return 2'b01;
        else return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic void mupd(int k, logic [1:0] g);
    logic [4:0] s;
    if (!rst_n) begin
      mreset(k);
      return;
    end
    if (g != 2'b00) begin
      s = g[1] ? (5'(a1) + 5'(b1))
               : (5'(a0) + 5'(b0));
      m_vld[k]  = 1'b1;
      m_id[k]   = g[1];
      m_sum[k]  = s[3:0];
      m_cout[k] = s[4];
      m_last[k] = g[1];
    end else if (m_vld[k] && rdy) begin
      m_vld[k] = 1'b0;
    end
  endfunction

  task automatic tick();
    logic [1:0] g0, g1;
    g0 = exp_gnt(0);
    g1 = exp_gnt(1);
    @(posedge clk);
    mupd(0, g0);
    mupd(1, g1);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mreset(0);
    mreset(1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mreset(0);
    mreset(1);
    req = 2'b11;
    rdy = 1'b1;
    @(negedge clk);
    nvec++;
    if ({if0.gnt, if1.gnt} !== 4'b0000) begin
      nerr++;
      $display("FAIL rst_gnt: got %b want 0000",
               {if0.gnt, if1.gnt});
    end
    nvec++;
    if ({if0.rsp_vld, if0.rsp_id, if0.rsp_sum,
         if0.rsp_cout} !== 7'd0) begin
      nerr++;
      $display("FAIL rst_out: got %b want 0",
               {if0.rsp_vld, if0.rsp_id,
                if0.rsp_sum, if0.rsp_cout});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a0 = 4'd1; b0 = 4'd2;
    @(negedge clk);
    nvec++;
    if ({if0.gnt, if1.gnt} !== 4'b0101) begin
      nerr++;
      $display("FAIL first_gnt: got %b want 0101",
               {if0.gnt, if1.gnt});
    end
    tick();
    req = 2'b00;
  endtask

  task automatic test_rr();
    logic [1:0] seq [4];
    seq[0] = 2'b01; seq[1] = 2'b10;
    seq[2] = 2'b01; seq[3] = 2'b10;
    do_reset();
    req = 2'b11;
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a0 = 4'($urandom); b0 = 4'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom);
      if (i == 4) req = 2'b00;
      @(negedge clk);
      if (i < 4) begin
        nvec++;
        if (if0.gnt !== seq[i]) begin
          nerr++;
          $display("FAIL rr_gnt%0d: got %b want %b",
                   i, if0.gnt, seq[i]);
        end
      end
      if (i > 0) begin
        nvec++;
        if (if0.rsp_id !== seq[i-1][1]
            || if0.rsp_vld !== 1'b1
            || if0.rsp_sum !== m_sum[0]) begin
          nerr++;
          $display("FAIL rr_rsp%0d: got v%b id%b s%0d want v1 id%b s%0d",
                   i, if0.rsp_vld, if0.rsp_id,
                   if0.rsp_sum, seq[i-1][1], m_sum[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_basic();
    do_reset();
    req = 2'b01;
    a0 = 4'd5; b0 = 4'd6;
    rdy = 1'b1;
    @(negedge clk);
    nvec++;
    if (if0.gnt !== 2'b01) begin
      nerr++;
      $display("FAIL basic_gnt: got %b want 01",
               if0.gnt);
    end
    tick();
    req = 2'b00;
    @(negedge clk);
    nvec++;
    if ({if0.rsp_vld, if0.rsp_id, if0.rsp_sum,
         if0.rsp_cout} !== {1'b1, 1'b0, 4'd11, 1'b0}) begin
      nerr++;
      $display("FAIL basic_rsp: got v%b id%b s%0d c%b want v1 id0 s11 c0",
               if0.rsp_vld, if0.rsp_id,
               if0.rsp_sum, if0.rsp_cout);
    end
    tick();
  endtask

  task automatic test_stall();
    rdy = 1'b1;
    req = 2'b01;
    a0 = 4'd2; b0 = 4'd7;
    tick();
    req = 2'b10;
    a1 = 4'd4; b1 = 4'd4;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if ({if0.gnt, if0.rsp_vld, if0.rsp_id,
           if0.rsp_sum, if0.rsp_cout}
          !== {2'b00, 1'b1, 1'b0, 4'd9, 1'b0}) begin
        nerr++;
        $display("FAIL stall%0d: got g%b v%b id%b s%0d want g00 v1 id0 s9",
                 i, if0.gnt, if0.rsp_vld,
                 if0.rsp_id, if0.rsp_sum);
      end
      tick();
    end
    rdy = 1'b1;
    @(negedge clk);
    nvec++;
    if (if0.gnt !== 2'b10) begin
      nerr++;
      $display("FAIL stall_release: got %b want 10",
               if0.gnt);
    end
    tick();
    req = 2'b00;
    @(negedge clk);
    nvec++;
    if ({if0.rsp_vld, if0.rsp_id, if0.rsp_sum}
        !== {1'b1, 1'b1, 4'd8}) begin
      nerr++;
      $display("FAIL stall_rsp: got v%b id%b s%0d want v1 id1 s8",
               if0.rsp_vld, if0.rsp_id, if0.rsp_sum);
    end
    tick();
  endtask

  task automatic test_overflow();
    rdy = 1'b1;
    req = 2'b10;
    a1 = 4'd15; b1 = 4'd1;
    tick();
    req = 2'b01;
    a0 = 4'd9; b0 = 4'd8;
    @(negedge clk);
    nvec++;
    if ({if0.rsp_sum, if0.rsp_cout} !== {4'd0, 1'b1}) begin
      nerr++;
      $display("FAIL ovf_15p1: got s%0d c%b want s0 c1",
               if0.rsp_sum, if0.rsp_cout);
    end
    tick();
    req = 2'b00;
    @(negedge clk);
    nvec++;
    if ({if0.rsp_sum, if0.rsp_cout} !== {4'd1, 1'b1}) begin
      nerr++;
      $display("FAIL ovf_9p8: got s%0d c%b want s1 c1",
               if0.rsp_sum, if0.rsp_cout);
    end
    tick();
  endtask

  task automatic test_async_reset();
    rdy = 1'b0;
    req = 2'b10;
    a1 = 4'd3; b1 = 4'd4;
    tick();
    req = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({if0.rsp_vld, if1.rsp_vld, if0.gnt} !== 4'b0000) begin
      nerr++;
      $display("FAIL async_rst: got v%b%b g%b want v00 g00",
               if0.rsp_vld, if1.rsp_vld, if0.gnt);
    end
    mreset(0);
    mreset(1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nvec++;
      if ({if0.rsp_vld, if1.rsp_vld} !== 2'b00) begin
        nerr++;
        $display("FAIL post_rst_vld%0d: got %b want 00",
                 i, {if0.rsp_vld, if1.rsp_vld});
      end
      tick();
    end
    req = 2'b11;
    @(negedge clk);
    nvec++;
    if (if0.gnt !== 2'b01) begin
      nerr++;
      $display("FAIL post_rst_gnt: got %b want 01",
               if0.gnt);
    end
    tick();
    req = 2'b00;
    tick();
  endtask

  task automatic test_fixed();
    rdy = 1'b1;
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      a0 = 4'($urandom); b0 = 4'($urandom);
      @(negedge clk);
      nvec++;
      if (if1.gnt !== 2'b01) begin
        nerr++;
        $display("FAIL fixed_gnt%0d: got %b want 01",
                 i, if1.gnt);
      end
      tick();
    end
    req = 2'b10;
    @(negedge clk);
    nvec++;
    if (if1.gnt !== 2'b10) begin
      nerr++;
      $display("FAIL fixed_r1: got %b want 10",
               if1.gnt);
    end
    tick();
    req = 2'b00;
    tick();
  endtask

  task automatic test_random();
    logic [8:0] o0, e0, o1, e1;
    for (int i = 0; i < 400; i++) begin
      req = 2'($urandom);
      a0 = 4'($urandom); b0 = 4'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      o0 = {if0.gnt, if0.rsp_vld, if0.rsp_id,
            if0.rsp_sum, if0.rsp_cout};
      e0 = {exp_gnt(0), m_vld[0], m_id[0],
            m_sum[0], m_cout[0]};
      o1 = {if1.gnt, if1.rsp_vld, if1.rsp_id,
            if1.rsp_sum, if1.rsp_cout};
      e1 = {exp_gnt(1), m_vld[1], m_id[1],
            m_sum[1], m_cout[1]};
      nvec++;
      if (o0 !== e0) begin
        nerr++;
        $display("FAIL rand_rr%0d: got %b want %b",
                 i, o0, e0);
      end
      nvec++;
      if (o1 !== e1) begin
        nerr++;
        $display("FAIL rand_fp%0d: got %b want %b",
                 i, o1, e1);
      end
      tick();
    end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_rr();
    test_basic();
    test_stall();
    test_overflow();
    test_async_reset();
    test_fixed();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
